ds_arb_rr: RTL and testbench

//  N-input round-robin arbiter multiplexing ds streams onto a single ds stream, e.g. sharing one
//  ds_fifo write port between several producers. Grant is held for a burst: the burst ends on
//  i_req_last or after MAX_BURST beats. A registered output stage isolates the downstream timing.

---
 rtl/ds_arb_rr_pkg.sv | 14 +
 rtl/ds_arb_rr_if.sv | 34 +++
 rtl/ds_arb_rr_pick.sv | 33 +++
 rtl/ds_arb_rr.sv | 120 ++++++++++++
 tb/tb_ds_arb_rr.sv | 259 +++++++++++++++++++++++++
 5 files changed

// File: rtl/ds_arb_rr_pkg.sv
// Shared types and helpers for the round-robin ds-stream arbiter.
package ds_arb_rr_pkg;

   typedef enum logic [0:0] {
      ARB_IDLE,
      ARB_LOCK
   } t_arb_state;

   // Index width for n items, never narrower than one bit.
   function automatic int sclog2(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/ds_arb_rr_if.sv
// Bundle of requester-side and downstream-side ds signals around the arbiter.
// Names are seen from the arbiter: i_* flow into it, o_* flow out of it.
interface ds_arb_rr_if #(
   parameter int N_REQ = 4,
   parameter int DW    = 8
);
   import ds_arb_rr_pkg::*;

   localparam int SW = sclog2(N_REQ);

   logic [N_REQ-1:0]         i_req_vld;
   logic [N_REQ-1:0][DW-1:0] i_req_data;
   logic [N_REQ-1:0]         i_req_last;
   logic [N_REQ-1:0]         o_req_rdy;
   logic                     o_vld;
   logic [DW-1:0]            o_data;
   logic                     o_last;
   logic [SW-1:0]            o_src;
   logic                     i_rdy;
   logic                     o_busy;

   // Arbiter side.
   modport slave (
      input  i_req_vld, i_req_data, i_req_last, i_rdy,
      output o_req_rdy, o_vld, o_data, o_last, o_src, o_busy
   );

   // Environment side: requesters plus downstream sink.
   modport master (
      output i_req_vld, i_req_data, i_req_last, i_rdy,
      input  o_req_rdy, o_vld, o_data, o_last, o_src, o_busy
   );

endinterface

// File: rtl/ds_arb_rr_pick.sv
// Rotating priority encoder: first set request at or after ptr, wrapping.
module ds_arb_rr_pick
   import ds_arb_rr_pkg::*;
#(
   parameter  int N  = 4,
   localparam int IW = sclog2(N)
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] ptr,
   output logic [IW-1:0] gnt_idx,
   output logic          gnt_any
);

   // Walk offsets high to low so the offset closest to ptr is written last and wins.
   always_comb begin
      int          idx;
      logic [IW-1:0] sel;
      idx     = 0;
      sel     = '0;
      gnt_idx = '0;
      gnt_any = 1'b0;
      for (int k = N - 1; k >= 0; k--) begin
         idx = int'(ptr) + k;
         if (idx >= N) idx = idx - N;
         sel = IW'(idx);
         if (req[sel]) begin
            gnt_idx = sel;
            gnt_any = 1'b1;
         end
      end
   end

endmodule

// File: rtl/ds_arb_rr.sv
// Round-robin arbiter merging N_REQ ds streams into one registered ds stream.
// A grant is held for a whole burst, ending on last or after MAX_BURST beats (0 = no cap).
module ds_arb_rr
   import ds_arb_rr_pkg::*;
#(
   parameter int N_REQ     = 4,
   parameter int DW        = 8,
   parameter int MAX_BURST = 8
) (
   input  logic       i_clk,
   input  logic       i_rst,
   ds_arb_rr_if.slave bus
);

   localparam int            SW       = sclog2(N_REQ);
   localparam int            CW       = sclog2(MAX_BURST + 1);
   localparam logic [CW-1:0] CNT_SAT  = '1;
   localparam logic [CW-1:0] CNT_LAST = (MAX_BURST > 0) ? CW'(MAX_BURST - 1) : '0;

   t_arb_state    state_q, state_d;
   logic [SW-1:0] ptr_q, ptr_d;
   logic [SW-1:0] grant_q, grant_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [SW-1:0] pick_idx;
   logic [SW-1:0] grant_inc;
   logic          pick_any;
   logic          out_free;
   logic          in_xfer;
   logic          burst_end;

   logic          vld_q;
   logic [DW-1:0] data_q;
   logic          last_q;
   logic [SW-1:0] src_q;

   ds_arb_rr_pick #(
      .N (N_REQ)
   ) u_pick (
      .req     (bus.i_req_vld),
      .ptr     (ptr_q),
      .gnt_idx (pick_idx),
      .gnt_any (pick_any)
   );

   // Output register can take a beat when empty or draining this cycle.
   assign out_free  = !vld_q || bus.i_rdy;
   assign in_xfer   = (state_q == ARB_LOCK) && bus.i_req_vld[grant_q] && out_free;
   assign burst_end = in_xfer &&
                      (bus.i_req_last[grant_q] || ((MAX_BURST > 0) && (cnt_q == CNT_LAST)));
   assign grant_inc = (int'(grant_q) == N_REQ - 1) ? '0 : grant_q + 1'b1;

   // Only the granted requester sees ready; i_rdy reaches it combinationally.
   always_comb begin
      bus.o_req_rdy = '0;
      if (state_q == ARB_LOCK) bus.o_req_rdy[grant_q] = out_free;
   end

   // Arbitrate in IDLE, count beats in LOCK, rotate ptr past the grant at burst end.
   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      grant_d = grant_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         ARB_IDLE: begin
            if (pick_any) begin
               grant_d = pick_idx;
               cnt_d   = '0;
               state_d = ARB_LOCK;
            end
         end
         ARB_LOCK: begin
            if (in_xfer && (cnt_q != CNT_SAT)) cnt_d = cnt_q + 1'b1;
            if (burst_end) begin
               ptr_d   = grant_inc;
               state_d = ARB_IDLE;
            end
         end
         default: state_d = ARB_IDLE;
      endcase
   end

   // Arbitration state registers.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q <= ARB_IDLE;
         ptr_q   <= '0;
         grant_q <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         grant_q <= grant_d;
         cnt_q   <= cnt_d;
      end
   end

   // Output stage: load on input transfer (even while draining), else clear once accepted.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         vld_q  <= 1'b0;
         last_q <= 1'b0;
         src_q  <= '0;
      end else if (in_xfer) begin
         vld_q  <= 1'b1;
         data_q <= bus.i_req_data[grant_q];
         last_q <= bus.i_req_last[grant_q];
         src_q  <= grant_q;
      end else if (bus.i_rdy) begin
         vld_q  <= 1'b0;
      end
   end

   assign bus.o_vld  = vld_q;
   assign bus.o_data = data_q;
   assign bus.o_last = last_q;
   assign bus.o_src  = src_q;
   assign bus.o_busy = (state_q == ARB_LOCK);

endmodule

// File: tb/tb_ds_arb_rr.sv
// Bench for ds_arb_rr: packet queues per requester, burst-level reference model,
// a table of round-robin rounds and hand sequences for latency, cap, backpressure, reset.
module tb_ds_arb_rr;
   import ds_arb_rr_pkg::*;

   localparam int N_REQ     = 4;
   localparam int DW        = 8;
   localparam int MAX_BURST = 8;
   localparam int HALF      = 5;

   logic i_clk = 1'b0;
   logic i_rst;
   always #HALF i_clk = ~i_clk;

   ds_arb_rr_if #(.N_REQ(N_REQ), .DW(DW)) bus ();

   ds_arb_rr #(
      .N_REQ     (N_REQ),
      .DW        (DW),
      .MAX_BURST (MAX_BURST)
   ) dut (
      .i_clk (i_clk),
      .i_rst (i_rst),
      .bus   (bus)
   );

   int          total = 0;
   int          bad   = 0;
   logic [8:0]  srcq [N_REQ][$];   // {last, data} per requester
   logic [10:0] got_q [$];         // {src, last, data}
   logic [10:0] exp_q [$];
   int          mptr = 0;
   int          rdy_mode = 0;      // 0: always ready, 1: random, 2: pattern
   logic        rdy_pat [$];
   logic        rst_cmd = 1'b1;
   int          first_vld_step;
   int          step_idx;
   logic        prev_hold = 1'b0;
   logic        prev_rst = 1'b1;
   logic [10:0] prev_beat = '0;

   typedef struct packed {
      logic [3:0] mask;
      logic [2:0] n;
      logic [7:0] order;   // entry k at [2k+1:2k]
   } rr_vec_t;
   rr_vec_t vecs [7];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %0h, want %0h", name, act, req);
      end
   endtask

   // One clock: drive at negedge, sample one unit before the next posedge.
   task automatic step();
      logic [10:0] beat;
      @(negedge i_clk);
      i_rst = rst_cmd;
      for (int r = 0; r < N_REQ; r++) begin
         bus.i_req_vld[r]  = (srcq[r].size() > 0);
         bus.i_req_data[r] = (srcq[r].size() > 0) ? srcq[r][0][7:0] : 8'h00;
         bus.i_req_last[r] = (srcq[r].size() > 0) ? srcq[r][0][8] : 1'b0;
      end
      case (rdy_mode)
         1:       bus.i_rdy = ($urandom_range(0, 3) != 0);
         2:       bus.i_rdy = (rdy_pat.size() > 0) ? rdy_pat.pop_front() : 1'b1;
         default: bus.i_rdy = 1'b1;
      endcase
      #(HALF - 1);
      beat = {bus.o_src, bus.o_last, bus.o_data};
      if (prev_hold && !prev_rst && !i_rst) begin
         check("hold_vld", {31'b0, bus.o_vld}, 1);
         check("hold_beat", {21'b0, beat}, {21'b0, prev_beat});
      end
      check("rdy_onehot", {31'b0, $onehot0(bus.o_req_rdy) && (bus.o_req_rdy == '0 || bus.o_busy)}, 1);
      if (!i_rst) begin
         for (int r = 0; r < N_REQ; r++)
            if (bus.i_req_vld[r] && bus.o_req_rdy[r]) void'(srcq[r].pop_front());
         if (bus.o_vld && bus.i_rdy) got_q.push_back(beat);
         if (bus.o_vld && first_vld_step < 0) first_vld_step = step_idx;
      end
      prev_hold = bus.o_vld && !bus.i_rdy;
      prev_beat = beat;
      prev_rst  = i_rst;
      step_idx++;
   endtask

   // Burst-level model: serve nonempty queues round-robin from mptr, a burst ends on
   // last or after MAX_BURST beats, then the pointer moves past the served requester.
   task automatic model_build();
      logic [8:0] mq [N_REQ][$];
      logic [8:0] b;
      int g;
      int n;
      bit done;
      for (int r = 0; r < N_REQ; r++) mq[r] = srcq[r];
      exp_q.delete();
      done = 1'b0;
      while (!done) begin
         g = -1;
         for (int k = 0; k < N_REQ; k++)
            if (g < 0 && mq[(mptr + k) % N_REQ].size() > 0) g = (mptr + k) % N_REQ;
         if (g < 0) begin
            done = 1'b1;
         end else begin
            n = 0;
            b = '0;
            do begin
               b = mq[g].pop_front();
               exp_q.push_back({2'(g), b});
               n++;
            end while (!b[8] && n != MAX_BURST && mq[g].size() > 0);
            mptr = (g + 1) % N_REQ;
         end
      end
   endtask

   task automatic run_scn(input string name, input int max_cyc);
      int cyc;
      model_build();
      got_q.delete();
      first_vld_step = -1;
      step_idx = 0;
      cyc = 0;
      while (got_q.size() < exp_q.size() && cyc < max_cyc) begin
         step();
         cyc++;
      end
      check({name, "_count"}, got_q.size(), exp_q.size());
      for (int k = 0; k < exp_q.size() && k < got_q.size(); k++)
         check({name, "_beat"}, {21'b0, got_q[k]}, {21'b0, exp_q[k]});
      repeat (3) step();
      check({name, "_busy_end"}, {31'b0, bus.o_busy}, 0);
      check({name, "_vld_end"}, {31'b0, bus.o_vld}, 0);
      check({name, "_extra"}, got_q.size(), exp_q.size());
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int cyc;
      int np;
      int len;
      vecs[0] = '{mask: 4'b1111, n: 3'd4, order: 8'hE4};
      vecs[1] = '{mask: 4'b0100, n: 3'd1, order: 8'h02};
      vecs[2] = '{mask: 4'b0011, n: 3'd2, order: 8'h04};
      vecs[3] = '{mask: 4'b1001, n: 3'd2, order: 8'h03};
      vecs[4] = '{mask: 4'b1111, n: 3'd4, order: 8'h39};
      vecs[5] = '{mask: 4'b0001, n: 3'd1, order: 8'h00};
      vecs[6] = '{mask: 4'b1010, n: 3'd2, order: 8'h0D};

      i_rst          = 1'b1;
      bus.i_req_vld  = '0;
      bus.i_req_data = '0;
      bus.i_req_last = '0;
      bus.i_rdy      = 1'b1;

      // Reset with every requester valid; then fairness 0,1,2,3.
      for (int r = 0; r < N_REQ; r++) srcq[r].push_back({1'b1, 8'(8'hA0 + r)});
      rst_cmd = 1'b1;
      step();
      step();
      check("rst_vld", {31'b0, bus.o_vld}, 0);
      check("rst_rdy", {28'b0, bus.o_req_rdy}, 0);
      check("rst_busy", {31'b0, bus.o_busy}, 0);
      rst_cmd = 1'b0;
      step();
      check("rst_rel_vld", {31'b0, bus.o_vld}, 0);
      check("rst_rel_busy", {31'b0, bus.o_busy}, 0);
      mptr = 0;
      run_scn("fair", 200);

      // Table of single-beat rounds with hand-derived grant order.
      for (int i = 0; i < 7; i++) begin
         for (int r = 0; r < N_REQ; r++)
            if (vecs[i].mask[r]) srcq[r].push_back({1'b1, 8'(16 * i + r)});
         run_scn("rr_row", 200);
         for (int k = 0; k < int'(vecs[i].n); k++)
            if (k < got_q.size())
               check("rr_table", {30'b0, got_q[k][10:9]}, {30'b0, vecs[i].order[2*k +: 2]});
      end

      // Burst cap: 16-beat packet on req0 with req2 pending.
      for (int b = 0; b < 16; b++) srcq[0].push_back({b == 15, 8'(b)});
      for (int b = 0; b < 8; b++) srcq[2].push_back({b == 7, 8'(8'h80 + b)});
      run_scn("cap", 400);
      for (int k = 0; k < 24 && k < got_q.size(); k++)
         check("cap_src", {30'b0, got_q[k][10:9]}, (k >= 8 && k < 16) ? 32'd2 : 32'd0);

      // Single requester, latency from vld rise to o_vld.
      srcq[1].push_back({1'b0, 8'h11});
      srcq[1].push_back({1'b0, 8'h22});
      srcq[1].push_back({1'b1, 8'h33});
      run_scn("single", 100);
      check("single_lat", first_vld_step, 2);
      if (got_q.size() > 0) check("single_src", {30'b0, got_q[0][10:9]}, 1);

      // Backpressure mid-burst.
      for (int b = 0; b < 6; b++) srcq[3].push_back({b == 5, 8'(8'h61 + b)});
      rdy_mode = 2;
      rdy_pat  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
      run_scn("bp", 200);
      rdy_mode = 0;

      // Random packets and random downstream readiness.
      rdy_mode = 1;
      for (int it = 0; it < 15; it++) begin
         for (int r = 0; r < N_REQ; r++) begin
            np = $urandom_range(0, 2);
            for (int p = 0; p < np; p++) begin
               len = $urandom_range(1, 12);
               for (int b = 0; b < len; b++)
                  srcq[r].push_back({b == len - 1, 8'($urandom_range(0, 255))});
            end
         end
         run_scn("rand", 3000);
      end
      rdy_mode = 0;

      // Reset mid-burst: move ptr to 3, interrupt req1 after 3 beats, check ptr restarts at 0.
      srcq[2].push_back({1'b1, 8'h2A});
      run_scn("pre_rst", 100);
      for (int b = 1; b <= 6; b++) srcq[1].push_back({b == 6, 8'(8'h40 + b)});
      got_q.delete();
      cyc = 0;
      while (got_q.size() < 3 && cyc < 100) begin
         step();
         cyc++;
      end
      check("mid_got3", got_q.size(), 3);
      for (int k = 0; k < 3 && k < got_q.size(); k++)
         check("mid_beat", {21'b0, got_q[k]}, {21'b0, 2'd1, k == 5, 8'(8'h41 + k)});
      rst_cmd = 1'b1;
      step();
      step();
      check("mid_rst_vld", {31'b0, bus.o_vld}, 0);
      check("mid_rst_busy", {31'b0, bus.o_busy}, 0);
      for (int r = 0; r < N_REQ; r++) srcq[r].delete();
      mptr = 0;
      rst_cmd = 1'b0;
      step();
      check("post_rst_vld", {31'b0, bus.o_vld}, 0);
      srcq[0].push_back({1'b1, 8'h70});
      srcq[3].push_back({1'b1, 8'h73});
      run_scn("post_rst", 100);
      if (got_q.size() > 0) check("post_rst_first", {30'b0, got_q[0][10:9]}, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
